// File: rtl/pack_pkg.sv
// rtl/pack_pkg.sv - shared framing constants and unpacker state type
package pack_pkg;

    localparam int SIZE_BIT_PACK   = 1976;
    localparam int SIZE_PREAMBLE   = 32;
    localparam int SIZE_OUTPUT_BIT = 8;

    localparam logic [SIZE_PREAMBLE-1:0] PREAMBLE_DATA  = 32'h1ACFFC1D;
    localparam logic [SIZE_PREAMBLE-1:0] PREAMBLE_BLANK = 32'hE53003E2;

    localparam int SIZE_PAYLOAD_BIT     = SIZE_BIT_PACK - SIZE_PREAMBLE;
    localparam int LENGTH_PAYLOAD_WORDS = SIZE_PAYLOAD_BIT / SIZE_OUTPUT_BIT;

    localparam int BIT_CNT_W  = $clog2(SIZE_BIT_PACK);
    localparam int CHK_CNT_W  = $clog2(SIZE_PREAMBLE) + 1;
    localparam int BYTE_IDX_W = $clog2(SIZE_OUTPUT_BIT);
    localparam int WORD_IDX_W = BIT_CNT_W - BYTE_IDX_W;

    typedef enum logic [1:0] {
        HUNT,
        DATA,
        SKIP,
        CHECK
    } unpack_state_t;

endpackage

// File: rtl/preamble_window.sv
// rtl/preamble_window.sv - 32-bit serial window with data/blank preamble match
//
// Ports:
//   i_clk, i_reset_n : clock, synchronous active-low reset
//   shift_en         : shift bit_in into the window LSB this cycle
//   bit_in           : serial bit
//   hit_data         : post-shift window equals the data preamble
//   hit_blank        : post-shift window equals the blank preamble
module preamble_window
    import pack_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic shift_en,
    input  logic bit_in,
    output logic hit_data,
    output logic hit_blank
);

    logic [SIZE_PREAMBLE-1:0] window_q;
    logic [SIZE_PREAMBLE-1:0] window_d;
    logic [SIZE_PREAMBLE-1:0] window_shift;

    // Matches are taken on the shifted value so the bit being accepted
    // this cycle already takes part in the compare.
    always_comb begin
        window_shift = {window_q[SIZE_PREAMBLE-2:0], bit_in};
        window_d     = shift_en ? window_shift : window_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            window_q <= '0;
        end else begin
            window_q <= window_d;
        end
    end

    assign hit_data  = shift_en && (window_shift == PREAMBLE_DATA);
    assign hit_blank = shift_en && (window_shift == PREAMBLE_BLANK);

endmodule

// File: rtl/frame_unpack.sv
// rtl/frame_unpack.sv - serial packet deframer: preamble hunt, lock, byte assembly
//
// Ports:
//   i_clk, i_reset_n         : clock, synchronous active-low reset
//   i_data, i_valid_input    : serial input bit and its qualifier
//   o_ready                  : bit is taken when i_valid_input && o_ready
//   o_data, o_valid          : assembled payload byte, first bit in o_data[7]
//   i_ready_output           : downstream accepts o_data
//   o_first, o_last          : byte 0 / last byte of a packet payload
//   o_locked, o_sync_loss    : frame lock status, one-cycle lock-loss pulse
module frame_unpack
    import pack_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_data,
    input  logic                       i_valid_input,
    output logic                       o_ready,
    output logic [SIZE_OUTPUT_BIT-1:0] o_data,
    output logic                       o_valid,
    input  logic                       i_ready_output,
    output logic                       o_first,
    output logic                       o_last,
    output logic                       o_locked,
    output logic                       o_sync_loss
);

    localparam logic [BIT_CNT_W-1:0]  PAYLOAD_LAST = BIT_CNT_W'(SIZE_PAYLOAD_BIT - 1);
    localparam logic [CHK_CNT_W-1:0]  CHECK_LAST   = CHK_CNT_W'(SIZE_PREAMBLE - 1);
    localparam logic [WORD_IDX_W-1:0] WORD_LAST    = WORD_IDX_W'(LENGTH_PAYLOAD_WORDS - 1);

    unpack_state_t state_q, state_d;
    logic [BIT_CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [CHK_CNT_W-1:0]       chk_cnt_q, chk_cnt_d;
    logic [SIZE_OUTPUT_BIT-2:0] byte_sr_q, byte_sr_d;
    logic [SIZE_OUTPUT_BIT-1:0] data_q, data_d;
    logic                       valid_q, valid_d;
    logic                       first_q, first_d;
    logic                       last_q, last_d;
    logic                       locked_q, locked_d;
    logic                       sync_loss_q, sync_loss_d;

    logic                  ready;
    logic                  accept;
    logic                  byte_done;
    logic [WORD_IDX_W-1:0] word_idx;
    logic                  hit_data;
    logic                  hit_blank;

    preamble_window u_window (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .shift_en  (accept),
        .bit_in    (i_data),
        .hit_data  (hit_data),
        .hit_blank (hit_blank)
    );

    // The next DATA bit finishes a byte; it can only be taken if the output
    // register is free now or is being emptied this very cycle.
    assign byte_done = (bit_cnt_q[BYTE_IDX_W-1:0] == {BYTE_IDX_W{1'b1}});
    assign ready     = !((state_q == DATA) && byte_done && valid_q && !i_ready_output);
    assign accept    = i_valid_input && ready;
    assign word_idx  = bit_cnt_q[BIT_CNT_W-1:BYTE_IDX_W];

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        chk_cnt_d   = chk_cnt_q;
        byte_sr_d   = byte_sr_q;
        data_d      = data_q;
        valid_d     = valid_q && !i_ready_output;
        first_d     = first_q;
        last_d      = last_q;
        locked_d    = locked_q;
        sync_loss_d = 1'b0;

        if (accept) begin
            case (state_q)
                HUNT: begin
                    if (hit_data) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end else if (hit_blank) begin
                        state_d   = SKIP;
                        bit_cnt_d = '0;
                    end
                end
                DATA, SKIP: begin
                    if (state_q == DATA) begin
                        byte_sr_d = {byte_sr_q[SIZE_OUTPUT_BIT-3:0], i_data};
                        if (byte_done) begin
                            data_d  = {byte_sr_q, i_data};
                            valid_d = 1'b1;
                            first_d = (word_idx == '0);
                            last_d  = (word_idx == WORD_LAST);
                        end
                    end
                    if (bit_cnt_q == PAYLOAD_LAST) begin
                        state_d   = CHECK;
                        bit_cnt_d = '0;
                        chk_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                CHECK: begin
                    if (chk_cnt_q == CHECK_LAST) begin
                        chk_cnt_d = '0;
                        bit_cnt_d = '0;
                        if (hit_data) begin
                            state_d  = DATA;
                            locked_d = 1'b1;
                        end else if (hit_blank) begin
                            state_d  = SKIP;
                            locked_d = 1'b1;
                        end else begin
                            // Lost alignment: resume hunting from the next bit.
                            state_d     = HUNT;
                            locked_d    = 1'b0;
                            sync_loss_d = 1'b1;
                        end
                    end else begin
                        chk_cnt_d = chk_cnt_q + 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q     <= HUNT;
            bit_cnt_q   <= '0;
            chk_cnt_q   <= '0;
            byte_sr_q   <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            locked_q    <= 1'b0;
            sync_loss_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            chk_cnt_q   <= chk_cnt_d;
            byte_sr_q   <= byte_sr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            first_q     <= first_d;
            last_q      <= last_d;
            locked_q    <= locked_d;
            sync_loss_q <= sync_loss_d;
        end
    end

    assign o_ready     = ready;
    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_first     = first_q;
    assign o_last      = last_q;
    assign o_locked    = locked_q;
    assign o_sync_loss = sync_loss_q;

endmodule

// File: tb/tb_frame_unpack.sv
// tb/tb_frame_unpack.sv - self-checking bench for frame_unpack
module tb_frame_unpack;
    import pack_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_data = 1'b0;
    logic       i_valid_input = 1'b0;
    logic       i_ready_output = 1'b1;
    logic       o_ready;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_first;
    logic       o_last;
    logic       o_locked;
    logic       o_sync_loss;

    always #5 i_clk = ~i_clk;

    frame_unpack dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_data         (i_data),
        .i_valid_input  (i_valid_input),
        .o_ready        (o_ready),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .i_ready_output (i_ready_output),
        .o_first        (o_first),
        .o_last         (o_last),
        .o_locked       (o_locked),
        .o_sync_loss    (o_sync_loss)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       f;
        logic       l;
    } exp_t;

    typedef struct {
        logic [31:0] pre;
        int          kind;       // payload: 0 count, 1 A5, 2 zeros, 3 random
        bit          stall;
        bit          rnd;
        int          exp_bytes;
        bit          exp_locked;
        int          exp_loss;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    bit   seg[$];
    exp_t exp_q[$];
    vec_t vecs[7];
    int   pkt_start[8];
    int   pkt_end[8];
    int   n_hs = 0;
    int   n_loss = 0;
    int   hs0;
    int   loss0;
    int   stall_cnt = 0;
    bit   rnd_ready = 0;
    bit   saw_ready_low = 0;
    bit   acc;
    bit   prev_hold = 0;
    bit   prev_loss = 0;
    logic [9:0] prev_word;
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_bits(input logic [31:0] v, input int nb);
        for (int b = nb - 1; b >= 0; b--) seg.push_back(v[b]);
    endtask

    // Reference: walk the bit stream by frame offsets. After a preamble the
    // payload occupies the next 1944 bits, then 32 bits must be a preamble
    // again; anything else drops back to scanning bit by bit.
    task automatic run_model();
        int          n;
        int          i;
        logic [31:0] w;
        logic [31:0] pre;
        bit          is_data;
        bit          in_frame;
        exp_t        e;
        n = seg.size();
        i = 0;
        w = '0;
        while (i < n) begin
            w = {w[30:0], seg[i]};
            i++;
            if (w == PREAMBLE_DATA || w == PREAMBLE_BLANK) begin
                is_data  = (w == PREAMBLE_DATA);
                in_frame = 1;
                while (in_frame) begin
                    if (is_data) begin
                        for (int k = 0; k < LENGTH_PAYLOAD_WORDS; k++) begin
                            if (i + 8 * k + 8 <= n) begin
                                e.d = '0;
                                for (int b = 0; b < 8; b++) e.d = {e.d[6:0], seg[i + 8 * k + b]};
                                e.f = (k == 0);
                                e.l = (k == LENGTH_PAYLOAD_WORDS - 1);
                                exp_q.push_back(e);
                            end
                        end
                    end
                    i += LENGTH_PAYLOAD_WORDS * 8;
                    if (i + SIZE_PREAMBLE > n) begin
                        i = n;
                        in_frame = 0;
                    end else begin
                        pre = '0;
                        for (int b = 0; b < SIZE_PREAMBLE; b++) pre = {pre[30:0], seg[i + b]};
                        i += SIZE_PREAMBLE;
                        w = pre;
                        if (pre == PREAMBLE_DATA) is_data = 1;
                        else if (pre == PREAMBLE_BLANK) is_data = 0;
                        else in_frame = 0;
                    end
                end
            end
        end
    endtask

    task automatic push_packet(input logic [31:0] pre, input int kind, input int nbytes);
        logic [7:0] b;
        push_bits(pre, 32);
        for (int w = 0; w < nbytes; w++) begin
            case (kind)
                0:       b = 8'(w);
                1:       b = 8'hA5;
                2:       b = 8'h00;
                default: b = 8'($urandom);
            endcase
            push_bits({24'd0, b}, 8);
        end
    endtask

    task automatic upd_ready();
        if (stall_cnt > 0) begin
            i_ready_output = 1'b0;
            stall_cnt--;
        end else if (rnd_ready) begin
            i_ready_output = ($urandom_range(0, 2) != 0);
        end else begin
            i_ready_output = 1'b1;
        end
    endtask

    task automatic send_bit(input bit b);
        int guard;
        if ($urandom_range(0, 4) == 0) begin
            i_valid_input = 1'b0;
            @(posedge i_clk);
            #1;
            upd_ready();
        end
        i_data = b;
        i_valid_input = 1'b1;
        guard = 0;
        forever begin
            @(negedge i_clk);
            acc = o_ready;
            @(posedge i_clk);
            #1;
            upd_ready();
            if (acc) break;
            guard++;
            if (guard > 200) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: o_ready low for %0d cycles, required 1", guard);
                break;
            end
        end
        i_valid_input = 1'b0;
    endtask

    task automatic drain();
        rnd_ready = 0;
        stall_cnt = 0;
        i_valid_input = 1'b0;
        i_ready_output = 1'b1;
        repeat (4) @(posedge i_clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        @(negedge i_clk);
        check({tag, "_valid"},  32'(o_valid), 32'd0);
        check({tag, "_first"},  32'(o_first), 32'd0);
        check({tag, "_last"},   32'(o_last), 32'd0);
        check({tag, "_locked"}, 32'(o_locked), 32'd0);
        check({tag, "_loss"},   32'(o_sync_loss), 32'd0);
        check({tag, "_ready"},  32'(o_ready), 32'd1);
        check({tag, "_data"},   32'(o_data), 32'd0);
    endtask

    // Output monitor: scoreboard pop on every handshake, hold checks while
    // stalled, sync-loss pulse width.
    always @(negedge i_clk) begin
        if (!i_reset_n) begin
            prev_hold <= 0;
            prev_loss <= 0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 32'(o_valid), 32'd1);
                check("hold_word", 32'({o_first, o_last, o_data}), 32'(prev_word));
            end
            if (o_valid && i_ready_output) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_byte: got %0h expected none", o_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("byte", 32'({o_first, o_last, o_data}), 32'({mon_e.f, mon_e.l, mon_e.d}));
                end
                n_hs++;
            end
            if (!i_ready_output && !o_ready) saw_ready_low <= 1;
            if (o_sync_loss) begin
                n_loss++;
                if (prev_loss) check("loss_pulse_width", 32'd2, 32'd1);
            end
            prev_loss <= o_sync_loss;
            prev_hold <= o_valid && !i_ready_output;
            prev_word <= {o_first, o_last, o_data};
        end
    end

    initial begin
        int k;
        vecs[0] = '{PREAMBLE_DATA,  0, 1'b0, 1'b0, 243, 1'b0, 0};
        vecs[1] = '{PREAMBLE_DATA,  1, 1'b0, 1'b0, 243, 1'b1, 0};
        vecs[2] = '{PREAMBLE_BLANK, 2, 1'b0, 1'b0,   0, 1'b1, 0};
        vecs[3] = '{PREAMBLE_DATA,  3, 1'b1, 1'b0, 243, 1'b1, 0};
        vecs[4] = '{32'h1ACFFC1C,   2, 1'b0, 1'b0,   0, 1'b0, 1};
        vecs[5] = '{PREAMBLE_DATA,  3, 1'b0, 1'b1, 243, 1'b0, 0};
        vecs[6] = '{PREAMBLE_DATA,  3, 1'b0, 1'b1, 243, 1'b1, 0};

        repeat (3) @(posedge i_clk);
        check_reset_vals("rst0");
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;

        // Segment 1: junk, seven table packets, then a packet cut at 1000 payload bits.
        push_bits($urandom, 5);
        for (int v = 0; v < 7; v++) begin
            pkt_start[v] = seg.size();
            push_packet(vecs[v].pre, vecs[v].kind, LENGTH_PAYLOAD_WORDS);
            pkt_end[v] = seg.size();
        end
        pkt_start[7] = seg.size();
        push_packet(PREAMBLE_DATA, 3, 125);
        pkt_end[7] = seg.size();
        run_model();

        k = 0;
        for (int j = 0; j < seg.size(); j++) begin
            if (k < 7 && j == pkt_start[k]) begin
                rnd_ready = vecs[k].rnd;
                hs0 = n_hs;
                loss0 = n_loss;
                saw_ready_low = 0;
            end
            if (k < 7 && vecs[k].stall && j == pkt_start[k] + 32 + 403) begin
                stall_cnt = 19;
                i_ready_output = 1'b0;
            end
            send_bit(seg[j]);
            if (k < 7 && j == pkt_end[k] - 1) begin
                drain();
                check($sformatf("vec%0d_bytes", k), 32'(n_hs - hs0), 32'(vecs[k].exp_bytes));
                check($sformatf("vec%0d_locked", k), 32'(o_locked), 32'(vecs[k].exp_locked));
                check($sformatf("vec%0d_loss", k), 32'(n_loss - loss0), 32'(vecs[k].exp_loss));
                if (vecs[k].stall) check($sformatf("vec%0d_ready_dropped", k), 32'(saw_ready_low), 32'd1);
                k++;
            end
        end

        // Reset in the middle of a locked data packet.
        drain();
        check("pre_reset_locked", 32'(o_locked), 32'd1);
        check("pre_reset_pending", 32'(exp_q.size()), 32'd0);
        i_reset_n = 1'b0;
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        check_reset_vals("rst_mid");

        // Segment 2: fresh data packet after reset must unpack from byte 0.
        seg.delete();
        exp_q.delete();
        push_packet(PREAMBLE_DATA, 0, LENGTH_PAYLOAD_WORDS);
        run_model();
        hs0 = n_hs;
        @(posedge i_clk);
        #1;
        for (int j = 0; j < seg.size(); j++) send_bit(seg[j]);
        drain();
        check("post_reset_bytes", 32'(n_hs - hs0), 32'd243);
        check("post_reset_locked", 32'(o_locked), 32'd0);
        check("post_reset_pending", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_unpack.md
Name: frame_unpack

Overview:
- Receive-side counterpart of the transmit packer. Consumes the serial 1-bit packet stream (MSB-first, 32-bit preamble + payload, back-to-back packets, blank packets as filler).
- Hunts for the data preamble, keeps frame lock, and re-assembles the payload into bytes in the original bit order.
- Discards blank packets.
- Sits between the bit-level demodulator/descrambler and the byte-level consumer.

Parameters:
- SIZE_BIT_PACK, 1976: total bits per packet, preamble included.
- SIZE_PREAMBLE, 32: preamble length in bits.
- SIZE_OUTPUT_BIT, 8: output word width.
- PREAMBLE_DATA, 32'h1ACFFC1D: preamble marking a data packet.
- PREAMBLE_BLANK, 32'hE53003E2: preamble marking a blank packet.
- LENGTH_PAYLOAD_WORDS, (SIZE_BIT_PACK-SIZE_PREAMBLE)/SIZE_OUTPUT_BIT = 243: derived, payload words per packet.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  synchronous reset, active low.
- i_data  in  1  serial bit.
- i_valid_input  in  1  i_data valid.
- o_ready  out  1  bit accepted when i_valid_input && o_ready.
- o_data  out  8  assembled payload byte; first received bit is in o_data[7].
- o_valid  out  1  o_data valid; held until i_ready_output.
- i_ready_output  in  1  downstream accepts o_data.
- o_first  out  1  qualifies byte 0 of a packet.
- o_last  out  1  qualifies byte 242 of a packet.
- o_locked  out  1  frame lock status.
- o_sync_loss  out  1  one-cycle pulse when lock is lost.

Behaviour:
- Reset (i_reset_n low at a rising edge) returns all state from any state, mid-packet included, and drops any partial byte:
  - state HUNT; o_valid, o_first, o_last, o_locked, o_sync_loss = 0; o_ready = 1; o_data = 0.
  - window register = 0; counters = 0.
- Window: a 32-bit shift register. Every accepted bit shifts in at the LSB in all states. Comparisons use the post-shift value, i.e. they include the current bit.
- HUNT:
  - window == PREAMBLE_DATA -> DATA, bit counter = 0.
  - window == PREAMBLE_BLANK -> SKIP.
  - Otherwise stay in HUNT. o_locked = 0.
- DATA:
  - Bits shift MSB-first into the byte assembler.
  - On the 8th bit, the byte is loaded into the output register: o_valid = 1 the cycle after the accepting edge. Latency is 1 cycle from the last bit to o_valid.
  - o_first is set for payload word 0 and o_last for word LENGTH_PAYLOAD_WORDS-1; both are registered with o_data.
  - After 1944 payload bits -> CHECK.
- SKIP: same bit counting as DATA but no output is produced; after 1944 bits -> CHECK.
- CHECK: collects exactly SIZE_PREAMBLE bits, then compares the window:
  - window == PREAMBLE_DATA -> DATA; window == PREAMBLE_BLANK -> SKIP. In both cases o_locked = 1.
  - Otherwise o_sync_loss pulses for 1 cycle, o_locked = 0, state -> HUNT. The missed window is not re-scanned; hunting resumes with the next bit.
- o_locked rises on the first successful CHECK, not on the initial HUNT match.
- Backpressure:
  - o_ready = 0 only when the next accepted bit would complete a byte in DATA while o_valid && !i_ready_output.
  - Simultaneous consume and byte completion in the same cycle is allowed with no bubble.
  - No bit is ever dropped; the upstream stalls.
- Handshake: o_data, o_first and o_last stay stable while o_valid && !i_ready_output.
- i_valid_input low: all state holds.
- Counter widths: payload bit counter is $clog2(SIZE_BIT_PACK) bits; CHECK counter is $clog2(SIZE_PREAMBLE)+1 bits. No wrap-around beyond the terminal counts.

Decomposition:
- Package pack_pkg holds:
  - SIZE_BIT_PACK, SIZE_PREAMBLE, PREAMBLE_DATA, PREAMBLE_BLANK, LENGTH_PAYLOAD_WORDS;
  - typedef enum logic [1:0] {HUNT, DATA, SKIP, CHECK} unpack_state_t.
- The packer shares the same constants from pack_pkg.
- One sub-module, preamble_window: 32-bit shifter plus the two equality compares, outputs hit_data and hit_blank.
- FSM, counters and byte assembler stay in the top module.

Test Plan:
- Reset release, then 5 junk bits, PREAMBLE_DATA, and payload bytes 0x00..0xF2 with i_ready_output=1:
  - exactly 243 bytes 0x00..0xF2 appear;
  - o_first only on 0x00, o_last only on 0xF2;
  - o_locked stays 0.
- Continue that stream with a second packet of PREAMBLE_DATA + 0xA5 payload -> o_locked = 1 after the 32nd preamble bit; 243 bytes of 0xA5 follow.
- Locked stream, then a packet with PREAMBLE_BLANK and 1944 zero bits -> no o_valid for the whole packet; o_locked stays 1.
- Locked stream, then a preamble with bit 0 flipped (32'h1ACFFC1C) -> o_sync_loss pulses exactly once; state HUNT, o_locked = 0; following bytes are not emitted until a fresh PREAMBLE_DATA.
- Hold i_ready_output=0 for 20 cycles mid-packet:
  - o_ready drops once the next byte would complete;
  - o_data stays stable;
  - after release, bytes continue with no loss and no duplicate.
- Assert i_reset_n low for 1 cycle at payload bit 1000 -> all outputs return to reset values next cycle; the next PREAMBLE_DATA packet is unpacked correctly from byte 0.
